// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
//
// Fetches one row of a sprite from an external sprite ROM during horizontal
// blanking into a ping-pong pair of line buffers. While the back buffer fills,
// the front buffer (filled on the previous line) answers per-pixel hit queries
// for the display scan.
//
// Ports
//   Clk         single clock, all state on rising edge
//   Reset_n     asynchronous active-low reset
//   line_start  one-cycle pulse at start of horizontal blanking
//   fetch_y     screen row displayed after the next line_start
//   spr_x/y     sprite top-left corner in screen coordinates
//   spr_en      sprite visible
//   DrawX       current scan X
//   rom_addr    registered sprite ROM read address
//   rom_idx     palette index from ROM (1-cycle latency), 0 = transparent
//   busy        fetch in progress (FETCH or DRAIN)
//   pix_hit     opaque sprite pixel at previous cycle's DrawX
//   pix_idx     palette index for pix_hit, 0 otherwise
//
// state | meaning
// IDLE  | no fetch in progress
// FETCH | issuing ROM addresses for columns 0..SPR_W-1
// DRAIN | capturing the last column, then marking the back buffer valid

module sprite_line_fetch #(
   parameter int SPR_W = 21,
   parameter int SPR_H = 21,
   parameter int AW    = 9
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          line_start,
   input  logic [9:0]    fetch_y,
   input  logic [9:0]    spr_x,
   input  logic [9:0]    spr_y,
   input  logic          spr_en,
   input  logic [9:0]    DrawX,
   output logic [AW-1:0] rom_addr,
   input  logic [1:0]    rom_idx,
   output logic          busy,
   output logic          pix_hit,
   output logic [1:0]    pix_idx
);

   localparam int            CW       = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
   localparam logic [9:0]    W10      = 10'(SPR_W);
   localparam logic [9:0]    H10      = 10'(SPR_H);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;

   // sel_q names the physical buffer acting as front; the other one is back.
   logic            sel_q;
   logic            back_sel;
   logic [1:0]      valid_q;
   logic [9:0]      x_q [2];
   logic [1:0]      mem [2][SPR_W];
   logic [CW-1:0]   col_q;

   logic [9:0]      row;
   logic            fetch_ok;
   logic [AW-1:0]   row_base;

   logic            wr_en;
   logic [CW-1:0]   wr_col;

   logic [9:0]      dx;
   logic [1:0]      front_pix;
   logic            hit_d;

   assign back_sel = ~sel_q;
   assign row      = fetch_y - spr_y;
   assign fetch_ok = spr_en && (row < H10);
   // row < SPR_H <= 2^AW whenever this is used, so narrowing row is safe.
   assign row_base = AW'(row) * AW'(SPR_W);
   assign busy     = (state_q == FETCH) || (state_q == DRAIN);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      wr_col  = '0;
      case (state_q)
         IDLE: ;
         FETCH: begin
            // Data for column col-1 arrives now; column 0 has no predecessor.
            if (col_q != '0) begin
               wr_en  = 1'b1;
               wr_col = col_q - CW'(1);
            end
            if (col_q == COL_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            wr_en   = 1'b1;
            wr_col  = COL_LAST;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // line_start aborts anything in flight; the partial fill is discarded.
      if (line_start) begin
         wr_en   = 1'b0;
         state_d = fetch_ok ? FETCH : IDLE;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sel_q    <= 1'b0;
         valid_q  <= '0;
         x_q[0]   <= '0;
         x_q[1]   <= '0;
         col_q    <= '0;
         rom_addr <= '0;
      end else if (line_start) begin
         // Old back becomes front with its flag and X untouched; the old
         // front becomes the new back and is invalid until a fill completes.
         sel_q          <= ~sel_q;
         valid_q[sel_q] <= 1'b0;
         if (fetch_ok) begin
            x_q[sel_q] <= spr_x;
            col_q      <= '0;
            rom_addr   <= row_base;
         end
      end else if (state_q == FETCH && col_q != COL_LAST) begin
         col_q    <= col_q + CW'(1);
         rom_addr <= rom_addr + AW'(1);
      end else if (state_q == DRAIN) begin
         valid_q[back_sel] <= 1'b1;
      end
   end

   // Buffer contents are never reset; valid flags gate every use.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < SPR_W; i++) begin
         if (wr_en && wr_col == CW'(i)) mem[back_sel][i] <= rom_idx;
      end
   end

   assign dx = DrawX - x_q[sel_q];

   always_comb begin
      front_pix = 2'd0;
      for (int i = 0; i < SPR_W; i++) begin
         if (dx == 10'(i)) front_pix = mem[sel_q][i];
      end
   end

   assign hit_d = valid_q[sel_q] && (dx < W10) && (front_pix != 2'd0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_hit <= 1'b0;
         pix_idx <= 2'd0;
      end else begin
         pix_hit <= hit_d;
         pix_idx <= hit_d ? front_pix : 2'd0;
      end
   end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a behavioural 1-cycle sprite ROM.
module tb_sprite_line_fetch;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       line_start = 1'b0;
   logic [9:0] fetch_y = '0;
   logic [9:0] spr_x = '0;
   logic [9:0] spr_y = '0;
   logic       spr_en = 1'b0;
   logic [9:0] DrawX = '0;
   logic [8:0] rom_addr;
   logic [1:0] rom_idx = 2'd0;
   logic       busy;
   logic       pix_hit;
   logic [1:0] pix_idx;

   int n_chk  = 0;
   int n_pass = 0;
   int rom_mode = 0;   // 0: idx = addr % 4, 1: every entry idx 3

   sprite_line_fetch #(.SPR_W(21), .SPR_H(21), .AW(9)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start),
      .fetch_y(fetch_y), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
      .DrawX(DrawX), .rom_addr(rom_addr), .rom_idx(rom_idx),
      .busy(busy), .pix_hit(pix_hit), .pix_idx(pix_idx)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (rom_mode == 1) rom_idx <= 2'd3;
      else               rom_idx <= rom_addr[1:0];
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse();
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   // Scan DrawX over [x_lo, x_hi] (mod 1024) and check the registered hit
   // against a sprite at sx whose row starts at ROM address base.
   task automatic scan(input string tag, input int x_lo, input int x_hi,
                       input int sx, input int base, input int vld);
      int dx, e_idx, e_hit;
      for (int d = x_lo; d <= x_hi; d++) begin
         DrawX = 10'(d % 1024);
         tick();
         dx    = ((d % 1024) - sx + 1024) % 1024;
         e_idx = (rom_mode == 1) ? 3 : (base + dx) % 4;
         e_hit = (vld != 0 && dx < 21 && e_idx != 0) ? 1 : 0;
         chk({tag, "_hit"}, int'(pix_hit), e_hit);
         chk({tag, "_idx"}, int'(pix_idx), e_hit ? e_idx : 0);
      end
   endtask

   initial begin
      int bcnt;

      // reset state
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_hit", int'(pix_hit), 0);
      chk("rst_idx", int'(pix_idx), 0);
      chk("rst_addr", int'(rom_addr), 0);
      tick();
      Reset_n = 1'b1;
      tick();

      // basic fetch of row 5: addresses 105..125, busy for 22 cycles
      spr_en = 1'b1; spr_x = 10'd100; spr_y = 10'd50; fetch_y = 10'd55;
      pulse();
      bcnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (busy) bcnt++;
         if (k < 21) chk("fetch_addr", int'(rom_addr), 105 + k);
         tick();
      end
      chk("busy_cycles", bcnt, 22);
      chk("addr_hold", int'(rom_addr), 125);

      // display that row; a new fetch of row 6 runs behind it
      fetch_y = 10'd56;
      pulse();
      scan("row5", 99, 121, 100, 105, 1);

      // rows outside the sprite: no fetch
      fetch_y = 10'd49;
      pulse();
      chk("nofetch49_busy", int'(busy), 0);
      tick();
      chk("nofetch49_busy2", int'(busy), 0);
      fetch_y = 10'd71;
      pulse();
      chk("nofetch71_busy", int'(busy), 0);
      scan("nofetch", 95, 125, 100, 0, 0);

      // abort 10 cycles into a fetch
      fetch_y = 10'd55;
      pulse();
      repeat (10) tick();
      chk("abort_pre_addr", int'(rom_addr), 115);
      fetch_y = 10'd60;
      pulse();
      chk("abort_restart_addr", int'(rom_addr), 210);
      chk("abort_busy", int'(busy), 1);
      scan("abort", 100, 120, 100, 0, 0);
      wait_idle();
      fetch_y = 10'd200;
      pulse();
      scan("row10", 99, 121, 100, 210, 1);

      // X wrap with sprite moved mid-fetch (front X stays 1015)
      rom_mode = 1;
      spr_x = 10'd1015; spr_y = 10'd300; fetch_y = 10'd300;
      pulse();
      tick();
      spr_x = 10'd500;
      wait_idle();
      fetch_y = 10'd0;
      pulse();
      scan("wrap", 1010, 1037, 1015, 0, 1);

      // reset mid-fetch
      rom_mode = 0;
      spr_x = 10'd100; spr_y = 10'd50; fetch_y = 10'd55;
      pulse();
      repeat (7) tick();
      chk("pre_rst_busy", int'(busy), 1);
      Reset_n = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_addr", int'(rom_addr), 0);
      chk("async_rst_hit", int'(pix_hit), 0);
      tick();
      Reset_n = 1'b1;
      tick();
      pulse();
      scan("post_rst", 95, 125, 100, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sprite_line_fetch.md
SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

Interface
REQ-001 Parameters: SPR_W, default 21, sprite width in pixels.
REQ-002 Parameters: SPR_H, default 21, sprite height in rows.
REQ-003 Parameters: AW, default 9, sprite ROM address width (SPR_W*SPR_H <= 2^AW).
REQ-004 Clk  in  1  single clock; all state on rising edge.
REQ-005 Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 line_start  in  1  one-cycle pulse at start of horizontal blanking.
REQ-007 fetch_y  in  10  screen row to be displayed after the next line_start.
REQ-008 spr_x  in  10  sprite left edge, screen X.
REQ-009 spr_y  in  10  sprite top edge, screen Y.
REQ-010 spr_en  in  1  sprite visible.
REQ-011 DrawX  in  10  current pixel X of the display scan.
REQ-012 rom_addr  out  AW  sprite ROM read address, registered.
REQ-013 rom_idx  in  2  palette index from sprite ROM; 0 = transparent.
REQ-014 busy  out  1  fetch in progress.
REQ-015 pix_hit  out  1  opaque sprite pixel at previous cycle's DrawX.
REQ-016 pix_idx  out  2  palette index for pix_hit; 0 when pix_hit=0.

Function
REQ-017 Two SPR_W x 2-bit line buffers (front, back), each with valid flag and latched X; ping-pong.
REQ-018 States: IDLE, FETCH, DRAIN.
REQ-019 On line_start, any state: back buffer becomes front (flag and X included); the new back is filled per REQ-020..022.
REQ-020 At line_start: row = fetch_y - spr_y, 10-bit modulo; fetch when spr_en=1 and row < SPR_H, else back_valid=0 and state IDLE.
REQ-021 Fetch start: latch spr_x as back X, back_valid=0, col=0, go FETCH; rom_addr = row*SPR_W + col, one new address per cycle.
REQ-022 ROM latency 1 cycle: rom_idx for an address is sampled the cycle after it appears on rom_addr and written to back[col].
REQ-023 FETCH issues cols 0..SPR_W-1 (SPR_W cycles), then DRAIN captures the last entry, sets back_valid=1, returns to IDLE; line_start to back_valid = SPR_W+1 cycles.
REQ-024 busy=1 in FETCH and DRAIN only.
REQ-025 line_start during FETCH/DRAIN: abort; partial back buffer swapped to front with valid=0; new fetch per REQ-020 next cycle.
REQ-026 Pixel lookup: dx = DrawX - front X, 10-bit modulo; pix_hit registered = front_valid and dx < SPR_W and front[dx] != 0; pix_idx = front[dx] when hit, else 0; latency 1 cycle.
REQ-027 Sprite spanning X wrap (spr_x > 1023-SPR_W+1) follows modulo dx; no clipping.
REQ-028 spr_x/spr_y/spr_en changes mid-fetch do not affect the fetch in progress; back X is the line_start value.
REQ-029 rom_addr never exceeds SPR_W*SPR_H-1; holds last value when not fetching.

Reset
REQ-030 Reset_n low: state IDLE, busy=0, pix_hit=0, pix_idx=0, rom_addr=0, both valid flags 0, both X=0.
REQ-031 Reset mid-fetch takes effect immediately; first line after Reset_n release gives pix_hit=0 for all DrawX.
REQ-032 Buffer contents need no reset; valid flags gate all output.

Verification
REQ-033 spr_en=1, spr_x=100, spr_y=50, fetch_y=55, line_start -> rom_addr 105..125 over 21 consecutive cycles, busy=1 exactly 22 cycles.
REQ-034 After REQ-033 fill, second line_start, ROM row 5 = index pattern -> DrawX 99 and 121 give pix_hit=0; DrawX 100..120 give pix_hit=(idx!=0), pix_idx=ROM[105+dx], one cycle later.
REQ-035 fetch_y=49 or 71 with spr_y=50 -> no fetch, busy stays 0, next line pix_hit=0 everywhere.
REQ-036 line_start again 10 cycles into a fetch -> new fetch restarts at col 0, swapped front invalid, pix_hit=0 that line.
REQ-037 spr_x=1015, row 0, all ROM idx=3 -> pix_hit=1 for DrawX 1015..1023 and 0..11, 0 at DrawX 12.
REQ-038 Reset_n low at fetch cycle 7 -> busy=0, rom_addr=0 asynchronously; after release, next line pix_hit=0.
